pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage core. It generates the per-stage stall and bubble controls for regF/regD/regE/regM/regW and sequences the memory-stage data-memory access through a request/response handshake. It also resolves load-use hazards and execute-stage redirects. It sits beside the stage registers and drives their `*_stall`/`*_bubble` inputs every cycle.

---
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: per-stage stall/bubble generation,
// memory-stage request/response sequencing and load-use / redirect hazard handling.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_is_load,
  input  logic [4:0]       e_rd,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_rs1_used,
  input  logic             d_rs2_used,
  input  logic             e_redirect,
  input  logic             m_mem_op,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  output logic             dmem_req_valid,
  output logic             regF_stall,
  output logic             regD_stall,
  output logic             regE_stall,
  output logic             regM_stall,
  output logic             regD_bubble,
  output logic             regE_bubble,
  output logic             regM_bubble,
  output logic             regW_bubble,
  output logic [CNT_W-1:0] mem_stall_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_busy;
  logic             load_use;

  // Memory access sequencer; DONE always returns to IDLE so a finished op is never re-issued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (m_mem_op) state_d = S_REQ;
        else          state_d = S_IDLE;
      end
      S_REQ: begin
        if (dmem_req_ready) state_d = S_WAIT;
        else                state_d = S_REQ;
      end
      S_WAIT: begin
        if (dmem_resp_valid) state_d = S_DONE;
        else                 state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_busy       = m_mem_op && (state_q != S_DONE);
  assign dmem_req_valid = (state_q == S_REQ);

  assign load_use = e_is_load && (e_rd != 5'd0) &&
                    ((d_rs1_used && (d_rs1 == e_rd)) || (d_rs2_used && (d_rs2 == e_rd)));

  // Hazard priority: memory stall freezes everything, then redirect flush, then load-use bubble
  always_comb begin
    regF_stall  = 1'b0;
    regD_stall  = 1'b0;
    regE_stall  = 1'b0;
    regM_stall  = 1'b0;
    regD_bubble = 1'b0;
    regE_bubble = 1'b0;
    regM_bubble = 1'b0;
    regW_bubble = 1'b0;
    if (mem_busy) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_stall  = 1'b1;
      regW_bubble = 1'b1;
    end else if (e_redirect) begin
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
    end else if (load_use) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_bubble = 1'b1;
    end else begin
      regF_stall  = 1'b0;
    end
  end

  // Stall-cycle counter wraps naturally at 2^CNT_W
  always_comb begin
    if (mem_busy) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          cnt_d = cnt_q;
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, memory sequencing,
// reset abandonment and counter wrap (on a CNT_W=4 instance).
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic e_is_load, d_rs1_used, d_rs2_used, e_redirect, m_mem_op, rdy, resp;
  logic [4:0] e_rd, d_rs1, d_rs2;
  logic req_v, fs, ds, es, ms, db, eb, mb, wb;
  logic [31:0] cnt;
  logic m_mem_op4, req_v4, fs4, ds4, es4, ms4, db4, eb4, mb4, wb4;
  logic [3:0] cnt4;
  logic [8:0] ctl, exp_ctl;
  int errors = 0;
  int checks = 0;

  localparam logic [8:0] C_ZERO  = 9'b0000_0000_0;
  localparam logic [8:0] C_MEM   = 9'b1111_0001_0;
  localparam logic [8:0] C_MEMRQ = 9'b1111_0001_1;
  localparam logic [8:0] C_REDIR = 9'b0000_1100_0;
  localparam logic [8:0] C_LU    = 9'b1100_0100_0;

  always #5 clk = ~clk;

  assign ctl = {fs, ds, es, ms, db, eb, mb, wb, req_v};

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .e_is_load(e_is_load), .e_rd(e_rd), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .e_redirect(e_redirect), .m_mem_op(m_mem_op),
    .dmem_req_ready(rdy), .dmem_resp_valid(resp), .dmem_req_valid(req_v),
    .regF_stall(fs), .regD_stall(ds), .regE_stall(es), .regM_stall(ms),
    .regD_bubble(db), .regE_bubble(eb), .regM_bubble(mb), .regW_bubble(wb), .mem_stall_cnt(cnt));

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .e_is_load(1'b0), .e_rd(5'd0), .d_rs1(5'd0), .d_rs2(5'd0),
    .d_rs1_used(1'b0), .d_rs2_used(1'b0), .e_redirect(1'b0), .m_mem_op(m_mem_op4),
    .dmem_req_ready(1'b0), .dmem_resp_valid(1'b0), .dmem_req_valid(req_v4),
    .regF_stall(fs4), .regD_stall(ds4), .regE_stall(es4), .regM_stall(ms4),
    .regD_bubble(db4), .regE_bubble(eb4), .regM_bubble(mb4), .regW_bubble(wb4), .mem_stall_cnt(cnt4));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    e_is_load = 1'b0; e_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
    d_rs1_used = 1'b0; d_rs2_used = 1'b0; e_redirect = 1'b0;
    m_mem_op = 1'b0; rdy = 1'b0; resp = 1'b0; m_mem_op4 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    if (ctl !== C_ZERO) begin $display("FAIL reset_ctl got=%b want=%b", ctl, C_ZERO); errors++; end
    checks++;
    if (cnt !== 32'd0) begin $display("FAIL reset_cnt got=%0d want=0", cnt); errors++; end
    checks++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    e_is_load = 1'b1; e_rd = 5'd5; d_rs2 = 5'd5; d_rs2_used = 1'b1; d_rs1 = 5'd3; d_rs1_used = 1'b1;
    @(negedge clk);
    if (ctl !== C_LU) begin $display("FAIL lu_rs2 got=%b want=%b", ctl, C_LU); errors++; end
    checks++;
    tick();
    // The load has advanced; regE now holds a non-load
    e_is_load = 1'b0;
    @(negedge clk);
    if (ctl !== C_ZERO) begin $display("FAIL lu_one_cycle got=%b want=%b", ctl, C_ZERO); errors++; end
    checks++;
    tick();
    e_is_load = 1'b1; e_rd = 5'd0; d_rs2 = 5'd0;
    @(negedge clk);
    if (ctl !== C_ZERO) begin $display("FAIL lu_x0 got=%b want=%b", ctl, C_ZERO); errors++; end
    checks++;
    tick();
    e_rd = 5'd5; d_rs2 = 5'd5; d_rs2_used = 1'b0;
    @(negedge clk);
    if (ctl !== C_ZERO) begin $display("FAIL lu_unused got=%b want=%b", ctl, C_ZERO); errors++; end
    checks++;
    tick();
    d_rs1 = 5'd5;
    @(negedge clk);
    if (ctl !== C_LU) begin $display("FAIL lu_rs1 got=%b want=%b", ctl, C_LU); errors++; end
    checks++;
    tick();
    e_redirect = 1'b1;
    @(negedge clk);
    if (ctl !== C_REDIR) begin $display("FAIL redir_over_lu got=%b want=%b", ctl, C_REDIR); errors++; end
    checks++;
    tick();
    clear_inputs();
  endtask

  // Memory op entering regM at cycle 0; rd extra ready-low cycles, rs extra resp-low cycles
  task automatic test_mem(input int rd, input int rs, input logic redir);
    int last;
    do_reset();
    last = 3 + rd + rs;
    m_mem_op = 1'b1;
    for (int c = 0; c <= last; c++) begin
      rdy  = (c == 1 + rd);
      resp = (c == 2 + rd + rs);
      e_redirect = redir && (c < last);
      if (c == last)                 exp_ctl = C_ZERO;
      else if (c >= 1 && c <= 1 + rd) exp_ctl = C_MEMRQ;
      else                           exp_ctl = C_MEM;
      @(negedge clk);
      if (ctl !== exp_ctl) begin
        $display("FAIL mem_r%0d_s%0d_c%0d got=%b want=%b", rd, rs, c, ctl, exp_ctl); errors++;
      end
      checks++;
      tick();
    end
    m_mem_op = 1'b0; rdy = 1'b0; resp = 1'b0; e_redirect = redir;
    @(negedge clk);
    if (cnt !== last) begin $display("FAIL mem_cnt got=%0d want=%0d", cnt, last); errors++; end
    checks++;
    if (redir) begin
      if (ctl !== C_REDIR) begin $display("FAIL redir_after_done got=%b want=%b", ctl, C_REDIR); errors++; end
      checks++;
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_mem_op = 1'b1; rdy = 1'b1; resp = 1'b1;
    for (int c = 0; c < 6; c++) begin
      // cycles 0..3 first op (DONE at 3), second op starts in IDLE at 4, REQ at 5
      case (c)
        1, 5:    exp_ctl = C_MEMRQ;
        3:       exp_ctl = C_ZERO;
        default: exp_ctl = C_MEM;
      endcase
      @(negedge clk);
      if (ctl !== exp_ctl) begin $display("FAIL b2b_c%0d got=%b want=%b", c, ctl, exp_ctl); errors++; end
      checks++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    m_mem_op = 1'b1; rdy = 1'b1;
    tick(); tick();
    // now in WAIT with two busy cycles counted
    if (cnt !== 32'd2) begin $display("FAIL pre_rst_cnt got=%0d want=2", cnt); errors++; end
    checks++;
    m_mem_op = 1'b0; rdy = 1'b0;
    rst = 1'b1;
    #1;
    if (cnt !== 32'd0) begin $display("FAIL async_rst_cnt got=%0d want=0", cnt); errors++; end
    checks++;
    tick();
    rst = 1'b0;
    resp = 1'b1;
    @(negedge clk);
    if (ctl !== C_ZERO) begin $display("FAIL late_resp_ctl got=%b want=%b", ctl, C_ZERO); errors++; end
    checks++;
    tick();
    resp = 1'b0;
    m_mem_op = 1'b1;
    @(negedge clk);
    // still IDLE: stall without request
    if (ctl !== C_MEM) begin $display("FAIL post_rst_idle got=%b want=%b", ctl, C_MEM); errors++; end
    checks++;
    if (cnt !== 32'd0) begin $display("FAIL post_rst_cnt got=%0d want=0", cnt); errors++; end
    checks++;
    tick();
    clear_inputs();
  endtask

  task automatic test_cnt_wrap();
    logic [3:0] want;
    do_reset();
    m_mem_op4 = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    @(negedge clk);
    if (cnt4 !== 4'd14) begin $display("FAIL wrap_pre got=%0d want=14", cnt4); errors++; end
    checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = (i == 0) ? 4'd15 : ((i == 1) ? 4'd0 : 4'd1);
      @(negedge clk);
      if (cnt4 !== want) begin $display("FAIL wrap_%0d got=%0d want=%0d", i, cnt4, want); errors++; end
      checks++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    #3;
    test_reset();
    test_load_use();
    test_mem(0, 0, 1'b0);
    test_mem(4, 2, 1'b0);
    test_mem(0, 0, 1'b1);
    test_back_to_back();
    test_reset_mid_wait();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
